pwm_carrier_cfg_ctrl: RTL and testbench
=======================================

# pwm_carrier_cfg_ctrl

Configuration sequencer for a `PWMWIDTH`-bit PWM carrier timer. It accepts new carrier settings (period, initial phase, count mode, sync mode) from the processor side through a valid/ready handshake and holds them in shadow registers. It commits them to the timer's configuration inputs only at a selected carrier event, so a period or phase change never truncates a carrier cycle mid-way. It sits between the PS register bank and one carrier timer; its active outputs drive the timer directly, and the timer's `carrier` output feeds back into it.

## Interface
- `PWMWIDTH`, 16: carrier/config width.
- `TIMEOUT`, 65535: maximum cycles spent waiting for an update event before forcing the commit; must be ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_valid`  in  1  request carries a new config.
- `cfg_ready`  out  1  controller can accept a config.
- `cfg_countmax`  in  PWMWIDTH  requested period.
- `cfg_init_carr`  in  PWMWIDTH  requested initial carrier/phase.
- `cfg_count_mode`  in  2  requested mode: 00 stop, 01 down, 10 up, 11 up-down.
- `cfg_syncmode`  in  2  requested sync mask.
- `cfg_upd_mode`  in  2  commit point: 00 immediate, 01 carrier==0, 10 carrier==countmax, 11 either.
- `carrier`  in  PWMWIDTH  live carrier from the timer.
- `countmax`, `init_carr`  out  PWMWIDTH  active config to the timer.
- `count_mode`, `syncmode`  out  2  active config to the timer.
- `busy`  out  1  shadow config pending.
- `commit_pulse`  out  1  one-cycle strobe; active outputs changed this cycle.
- `cfg_err`  out  1  one-cycle strobe; request rejected.
- `timeout_flag`  out  1  sticky; the last commit was forced by timeout.

## Operation
- FSM states: IDLE and WAIT.
- **IDLE:** `cfg_ready`=1, `busy`=0.
  - A request is accepted on a rising edge with `cfg_valid` & `cfg_ready`.
  - On acceptance, all `cfg_*` fields (including `cfg_upd_mode`) are latched into shadow registers.
  - `timeout_flag` clears, the wait counter clears, and the FSM moves to WAIT.
- **Reject rule:** a request with `cfg_countmax`==0 and `cfg_count_mode`≠00 still completes the handshake, but:
  - it is not latched, and the FSM stays in IDLE;
  - `cfg_err`=1 for the following cycle;
  - active outputs are unchanged.
- **WAIT:** `cfg_ready`=0, `busy`=1. The wait counter increments each cycle, saturating at `TIMEOUT`. `evt` is true when any of these holds:
  - shadow `upd_mode`=00;
  - `upd_mode` bit0 set and `carrier`==0;
  - `upd_mode` bit1 set and `carrier`==active `countmax`;
  - active `count_mode`=00 or active `countmax`=0 (timer stopped, so no event would ever arrive).
- **Commit:** on the edge where `evt` holds, or the counter has reached `TIMEOUT` (sets `timeout_flag`):
  - shadow is copied to the active outputs, all fields on the same edge (never partial);
  - `commit_pulse`=1 for one cycle;
  - the FSM returns to IDLE.
- **Comparisons:** all comparisons use the active (not shadow) `countmax`; all are unsigned and `PWMWIDTH` wide. No arithmetic overflow is possible.
- **Simultaneous events:** a new `cfg_valid` during WAIT is back-pressured (`cfg_ready`=0). If `evt` and timeout occur on the same edge, `timeout_flag` stays 0.
- **Reset, at any time:** FSM→IDLE, pending shadow discarded, and outputs take their reset values.
- **Reset values:** `countmax`=0, `init_carr`=0, `count_mode`=00, `syncmode`=00, `cfg_ready`=1, `busy`=0, `commit_pulse`=0, `cfg_err`=0, `timeout_flag`=0.

## Timing
- All outputs are registered.
- Acceptance edge N → `busy`=1 and `cfg_ready`=0 from N.
- Immediate mode (or timer stopped): commit at edge N+1, and `cfg_ready` returns to 1 after N+1.
- Event mode: commit at the first edge N+k (k≥1) where `evt` is sampled true. Latency is at most `TIMEOUT`+1 edges.
- `commit_pulse` is high exactly in the cycle after the commit edge, aligned with the new output values.
- `cfg_err` is high in the cycle after the reject edge.
- Minimum spacing between two accepted configs is 2 cycles.

## Test plan
- **Reset:** assert `rst` mid-WAIT → all outputs at reset values next cycle; `cfg_ready`=1; no `commit_pulse`.
- **Immediate update:** active mode stopped; request countmax=100, mode=10, upd=00 → `commit_pulse` one cycle after the edge following acceptance; `countmax`=100, `count_mode`=10.
- **Zero-aligned update:** active countmax=100 up-down, carrier at 37 rising; request countmax=50, upd=01 → `busy` held until carrier==0; commit on that edge; no earlier output change.
- **Max-aligned update and back-pressure:** upd=10, second `cfg_valid` asserted during WAIT → `cfg_ready`=0 until commit after carrier==100; second request accepted the cycle after.
- **Timeout:** `TIMEOUT`=8, upd=10, carrier held at 5 → forced commit on the 9th edge after acceptance; `timeout_flag`=1 until the next accepted request.
- **Reject:** request countmax=0, mode=11 → `cfg_err` pulses one cycle; FSM stays IDLE; active config unchanged.

Source files
------------

// File: rtl/pwm_carrier_cfg_ctrl.sv
// pwm_carrier_cfg_ctrl
// Accepts new carrier settings through a valid/ready handshake and holds
// them in shadow registers. They are committed to the timer-facing outputs
// only at a selected carrier event, so a carrier cycle is never cut short.
// If no event arrives within TIMEOUT cycles, the commit is forced and
// flagged.
module pwm_carrier_cfg_ctrl #(
    parameter int PWMWIDTH = 16,
    parameter int TIMEOUT  = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [PWMWIDTH-1:0] cfg_countmax_i,
    input  logic [PWMWIDTH-1:0] cfg_init_carr_i,
    input  logic [1:0]          cfg_count_mode_i,
    input  logic [1:0]          cfg_syncmode_i,
    input  logic [1:0]          cfg_upd_mode_i,
    input  logic [PWMWIDTH-1:0] carrier_i,
    output logic [PWMWIDTH-1:0] countmax_o,
    output logic [PWMWIDTH-1:0] init_carr_o,
    output logic [1:0]          count_mode_o,
    output logic [1:0]          syncmode_o,
    output logic                busy_o,
    output logic                commit_pulse_o,
    output logic                cfg_err_o,
    output logic                timeout_flag_o
);

    // The wait counter only has to reach TIMEOUT, where it saturates.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       wcnt_q, wcnt_d;

    // Shadow copy of the accepted request.
    logic [PWMWIDTH-1:0] shCmax_q, shCmax_d;
    logic [PWMWIDTH-1:0] shInit_q, shInit_d;
    logic [1:0]          shMode_q, shMode_d;
    logic [1:0]          shSync_q, shSync_d;
    logic [1:0]          shUpd_q, shUpd_d;

    // Active configuration seen by the timer.
    logic [PWMWIDTH-1:0] actCmax_q, actCmax_d;
    logic [PWMWIDTH-1:0] actInit_q, actInit_d;
    logic [1:0]          actMode_q, actMode_d;
    logic [1:0]          actSync_q, actSync_d;

    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                commit_q, commit_d;
    logic                err_q, err_d;
    logic                tflag_q, tflag_d;

    logic                evt;
    logic                timerStopped;

    // A stopped timer never produces an event, so it always counts as one.
    always_comb begin
        timerStopped = (actMode_q == 2'b00) || (actCmax_q == '0);
        evt = (shUpd_q == 2'b00)
           || (shUpd_q[0] && (carrier_i == '0))
           || (shUpd_q[1] && (carrier_i == actCmax_q))
           || timerStopped;
    end

    // Next-state logic: handshake and reject in IDLE, event/timeout commit in WAIT.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        shCmax_d  = shCmax_q;
        shInit_d  = shInit_q;
        shMode_d  = shMode_q;
        shSync_d  = shSync_q;
        shUpd_d   = shUpd_q;
        actCmax_d = actCmax_q;
        actInit_d = actInit_q;
        actMode_d = actMode_q;
        actSync_d = actSync_q;
        tflag_d   = tflag_q;
        commit_d  = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid_i) begin
                    if ((cfg_countmax_i == '0) && (cfg_count_mode_i != 2'b00)) begin
                        err_d = 1'b1;
                    end else begin
                        shCmax_d = cfg_countmax_i;
                        shInit_d = cfg_init_carr_i;
                        shMode_d = cfg_count_mode_i;
                        shSync_d = cfg_syncmode_i;
                        shUpd_d  = cfg_upd_mode_i;
                        wcnt_d   = '0;
                        tflag_d  = 1'b0;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (evt || (wcnt_q == TMAX)) begin
                    actCmax_d = shCmax_q;
                    actInit_d = shInit_q;
                    actMode_d = shMode_q;
                    actSync_d = shSync_q;
                    commit_d  = 1'b1;
                    tflag_d   = ~evt;
                    state_d   = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_WAIT);
    end

    // State and output registers; reset discards any pending shadow config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            shCmax_q  <= '0;
            shInit_q  <= '0;
            shMode_q  <= 2'b00;
            shSync_q  <= 2'b00;
            shUpd_q   <= 2'b00;
            actCmax_q <= '0;
            actInit_q <= '0;
            actMode_q <= 2'b00;
            actSync_q <= 2'b00;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            commit_q  <= 1'b0;
            err_q     <= 1'b0;
            tflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            shCmax_q  <= shCmax_d;
            shInit_q  <= shInit_d;
            shMode_q  <= shMode_d;
            shSync_q  <= shSync_d;
            shUpd_q   <= shUpd_d;
            actCmax_q <= actCmax_d;
            actInit_q <= actInit_d;
            actMode_q <= actMode_d;
            actSync_q <= actSync_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            commit_q  <= commit_d;
            err_q     <= err_d;
            tflag_q   <= tflag_d;
        end
    end

    assign cfg_ready_o    = ready_q;
    assign busy_o         = busy_q;
    assign commit_pulse_o = commit_q;
    assign cfg_err_o      = err_q;
    assign timeout_flag_o = tflag_q;
    assign countmax_o     = actCmax_q;
    assign init_carr_o    = actInit_q;
    assign count_mode_o   = actMode_q;
    assign syncmode_o     = actSync_q;

endmodule

// File: tb/tb_pwm_carrier_cfg_ctrl.sv
// Directed bench for pwm_carrier_cfg_ctrl with TIMEOUT shortened to 8.
module tb_pwm_carrier_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfgValid;
    logic        cfgReady;
    logic [15:0] cfgCountmax;
    logic [15:0] cfgInitCarr;
    logic [1:0]  cfgCountMode;
    logic [1:0]  cfgSyncmode;
    logic [1:0]  cfgUpdMode;
    logic [15:0] carrier;
    logic [15:0] countmax;
    logic [15:0] initCarr;
    logic [1:0]  countMode;
    logic [1:0]  syncmode;
    logic        busy;
    logic        commitPulse;
    logic        cfgErr;
    logic        timeoutFlag;

    int nAsserts = 0;
    int nFail    = 0;

    pwm_carrier_cfg_ctrl #(.PWMWIDTH(16), .TIMEOUT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid_i      (cfgValid),
        .cfg_ready_o      (cfgReady),
        .cfg_countmax_i   (cfgCountmax),
        .cfg_init_carr_i  (cfgInitCarr),
        .cfg_count_mode_i (cfgCountMode),
        .cfg_syncmode_i   (cfgSyncmode),
        .cfg_upd_mode_i   (cfgUpdMode),
        .carrier_i        (carrier),
        .countmax_o       (countmax),
        .init_carr_o      (initCarr),
        .count_mode_o     (countMode),
        .syncmode_o       (syncmode),
        .busy_o           (busy),
        .commit_pulse_o   (commitPulse),
        .cfg_err_o        (cfgErr),
        .timeout_flag_o   (timeoutFlag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] cmax, input logic [15:0] init,
                                 input logic [1:0] mode, input logic [1:0] sync, input logic [1:0] upd);
        cfgValid     = v;
        cfgCountmax  = cmax;
        cfgInitCarr  = init;
        cfgCountMode = mode;
        cfgSyncmode  = sync;
        cfgUpdMode   = upd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        carrier = 16'd0;
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        step();
        step();
        checkOutput("rst_countmax", 32'(countmax), 32'd0);
        checkOutput("rst_mode", 32'(countMode), 32'd0);
        checkOutput("rst_ready", 32'(cfgReady), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_commit", 32'(commitPulse), 32'd0);
        checkOutput("rst_err", 32'(cfgErr), 32'd0);
        checkOutput("rst_tflag", 32'(timeoutFlag), 32'd0);
        rst = 1'b0;
        step();

        // Immediate update while the timer is stopped
        applyStimulus(1'b1, 16'd100, 16'd3, 2'b10, 2'b01, 2'b00);
        step();
        checkOutput("imm_acc_ready", 32'(cfgReady), 32'd0);
        checkOutput("imm_acc_busy", 32'(busy), 32'd1);
        checkOutput("imm_acc_cmax_old", 32'(countmax), 32'd0);
        checkOutput("imm_acc_commit", 32'(commitPulse), 32'd0);
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        step();
        checkOutput("imm_commit", 32'(commitPulse), 32'd1);
        checkOutput("imm_cmax", 32'(countmax), 32'd100);
        checkOutput("imm_init", 32'(initCarr), 32'd3);
        checkOutput("imm_mode", 32'(countMode), 32'd2);
        checkOutput("imm_sync", 32'(syncmode), 32'd1);
        checkOutput("imm_ready", 32'(cfgReady), 32'd1);
        checkOutput("imm_busy", 32'(busy), 32'd0);
        step();
        checkOutput("imm_commit_once", 32'(commitPulse), 32'd0);

        // Put the timer in up-down with period 100
        applyStimulus(1'b1, 16'd100, 16'd0, 2'b11, 2'b00, 2'b00);
        step();
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        step();
        checkOutput("ud_mode", 32'(countMode), 32'd3);

        // Zero-aligned update
        carrier = 16'd37;
        applyStimulus(1'b1, 16'd50, 16'd5, 2'b11, 2'b10, 2'b01);
        step();
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        for (int i = 38; i <= 40; i++) begin
            carrier = 16'(i);
            step();
            checkOutput("zero_wait_busy", 32'(busy), 32'd1);
            checkOutput("zero_wait_cmax", 32'(countmax), 32'd100);
            checkOutput("zero_wait_commit", 32'(commitPulse), 32'd0);
        end
        carrier = 16'd0;
        step();
        checkOutput("zero_commit", 32'(commitPulse), 32'd1);
        checkOutput("zero_cmax", 32'(countmax), 32'd50);
        checkOutput("zero_init", 32'(initCarr), 32'd5);
        checkOutput("zero_sync", 32'(syncmode), 32'd2);
        checkOutput("zero_tflag", 32'(timeoutFlag), 32'd0);

        // Max-aligned update with a second request held during WAIT
        carrier = 16'd10;
        applyStimulus(1'b1, 16'd100, 16'd0, 2'b10, 2'b00, 2'b10);
        step();
        applyStimulus(1'b1, 16'd200, 16'd7, 2'b01, 2'b11, 2'b00);
        carrier = 16'd20;
        step();
        checkOutput("max_bp_ready", 32'(cfgReady), 32'd0);
        checkOutput("max_bp_cmax", 32'(countmax), 32'd50);
        carrier = 16'd100;
        step();
        checkOutput("max_shadow_cmp_busy", 32'(busy), 32'd1);
        checkOutput("max_shadow_cmp_commit", 32'(commitPulse), 32'd0);
        carrier = 16'd50;
        step();
        checkOutput("max_commit", 32'(commitPulse), 32'd1);
        checkOutput("max_cmax", 32'(countmax), 32'd100);
        checkOutput("max_mode", 32'(countMode), 32'd2);
        checkOutput("max_ready", 32'(cfgReady), 32'd1);
        step();
        checkOutput("second_acc_busy", 32'(busy), 32'd1);
        checkOutput("second_acc_cmax", 32'(countmax), 32'd100);
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        step();
        checkOutput("second_commit", 32'(commitPulse), 32'd1);
        checkOutput("second_cmax", 32'(countmax), 32'd200);
        checkOutput("second_mode", 32'(countMode), 32'd1);
        checkOutput("second_init", 32'(initCarr), 32'd7);

        // Timeout: carrier never reaches countmax
        carrier = 16'd5;
        applyStimulus(1'b1, 16'd300, 16'd0, 2'b10, 2'b00, 2'b10);
        step();
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        for (int i = 1; i <= 8; i++) begin
            step();
            checkOutput("to_wait_busy", 32'(busy), 32'd1);
            checkOutput("to_wait_commit", 32'(commitPulse), 32'd0);
        end
        step();
        checkOutput("to_commit", 32'(commitPulse), 32'd1);
        checkOutput("to_flag", 32'(timeoutFlag), 32'd1);
        checkOutput("to_cmax", 32'(countmax), 32'd300);
        step();
        checkOutput("to_flag_sticky", 32'(timeoutFlag), 32'd1);
        checkOutput("to_commit_once", 32'(commitPulse), 32'd0);
        applyStimulus(1'b1, 16'd400, 16'd0, 2'b10, 2'b00, 2'b00);
        step();
        checkOutput("to_flag_clr", 32'(timeoutFlag), 32'd0);
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        step();
        checkOutput("to_next_cmax", 32'(countmax), 32'd400);
        checkOutput("to_next_flag", 32'(timeoutFlag), 32'd0);

        // Reject: zero period with a running mode
        applyStimulus(1'b1, 16'd0, 16'd0, 2'b11, 2'b00, 2'b00);
        step();
        checkOutput("rej_err", 32'(cfgErr), 32'd1);
        checkOutput("rej_ready", 32'(cfgReady), 32'd1);
        checkOutput("rej_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        step();
        checkOutput("rej_err_once", 32'(cfgErr), 32'd0);
        checkOutput("rej_commit", 32'(commitPulse), 32'd0);
        checkOutput("rej_cmax", 32'(countmax), 32'd400);
        checkOutput("rej_mode", 32'(countMode), 32'd2);

        // Stopped timer counts as an event even in max-aligned mode
        applyStimulus(1'b1, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        step();
        checkOutput("stop_acc_err", 32'(cfgErr), 32'd0);
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        step();
        checkOutput("stop_mode", 32'(countMode), 32'd0);
        carrier = 16'd5;
        applyStimulus(1'b1, 16'd77, 16'd0, 2'b10, 2'b00, 2'b10);
        step();
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        step();
        checkOutput("stop_commit", 32'(commitPulse), 32'd1);
        checkOutput("stop_cmax", 32'(countmax), 32'd77);

        // Reset in the middle of WAIT
        carrier = 16'd9;
        applyStimulus(1'b1, 16'd123, 16'd0, 2'b10, 2'b00, 2'b01);
        step();
        applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00);
        step();
        checkOutput("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_cmax", 32'(countmax), 32'd0);
        checkOutput("mid_rst_mode", 32'(countMode), 32'd0);
        checkOutput("mid_rst_ready", 32'(cfgReady), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_commit", 32'(commitPulse), 32'd0);
        step();
        rst = 1'b0;
        carrier = 16'd0;
        step();
        checkOutput("post_rst_commit", 32'(commitPulse), 32'd0);
        checkOutput("post_rst_cmax", 32'(countmax), 32'd0);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
